spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
// - SPI flash responder (slave) model for the SPI master / XIP flash path. It answers the READ command (0x03) from the SPI master.
// - Decodes a 24-bit address and streams bytes, MSB first, from an internal word memory. Runs in the system clock domain.
// - Placed on spi_ss[0], spi_sck, spi_mosi and spi_miso of the SPI master for simulation and FPGA bring-up.
// PARAMETERS
// - MEM_WORDS    1024  depth of the 32-bit backing memory; must be a power of 2.
// - SYNC_STAGES  2     flops on the synchronizers for spi_sck, spi_ss_n and spi_mosi.
// PORTS
// - clock       in   1   system clock.
// - reset       in   1   synchronous, active-high.
// - spi_sck     in   1   SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
// - spi_ss_n    in   1   chip select, active low.
// - spi_mosi    in   1   serial data from the master.
// - spi_miso    out  1   serial data to the master.
// - load_en     in   1   backdoor memory write strobe.
// - load_addr   in   $clog2(MEM_WORDS)  backdoor word address.
// - load_data   in   32  backdoor write data.
// - active      out  1   high while a transaction is selected.
// - bad_cmd     out  1   1-cycle pulse when an unsupported opcode is received.
// BEHAVIOUR
// - Reset values: spi_miso=0, active=0, bad_cmd=0, state=IDLE, counters=0. Memory contents are not reset.
// - Input sampling: spi_sck, spi_ss_n and spi_mosi each pass through SYNC_STAGES flops.
//   - sck_rise and sck_fall are single-cycle pulses from the synchronized spi_sck and its previous value.
// - Timing requirement: SCK high and low phases are each >= SYNC_STAGES+2 clocks.
// - Bit timing: MOSI is sampled on sck_rise. spi_miso is updated on sck_fall, or on entry to DATA.
// - Byte mapping: byte address a selects mem[a>>2][31-8*(a%4) -: 8], big-endian.
//   - A 32-bit read through the bridge therefore returns the word exactly as loaded.
// - FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
//   - IDLE: synchronized ss_n falls -> CMD; bit_cnt=0; active=1.
//   - CMD: shift in 8 bits. On the 8th sck_rise:
//     - opcode 0x03 -> ADDR.
//     - any other opcode -> IGNORE, with bad_cmd pulsed for 1 cycle.
//   - ADDR: shift in 24 bits. On the 24th sck_rise:
//     - latch the address modulo 4*MEM_WORDS.
//     - fetch that byte into tx_shift.
//     - -> DATA.
//   - DATA: spi_miso = tx_shift[7]. Each sck_fall shifts tx_shift left by one.
//     - After 8 bits: address += 1, wrapping 4*MEM_WORDS-1 -> 0, and the next byte is loaded into tx_shift.
//     - spi_miso then shows the new byte's MSB on the same sck_fall.
//     - Streaming is unlimited.
//   - IGNORE: spi_miso=0 and all SCK activity is ignored.
// - Deselect: synchronized ss_n rising in any state -> IDLE on the next cycle.
//   - active=0, spi_miso=0, partial command/address discarded.
// - Reset mid-transaction: IDLE immediately. The master must deassert ss_n before a new command is accepted.
// - spi_miso is 0 whenever the block is not in DATA.
// - Backdoor write: mem[load_addr] updates on the clock edge where load_en=1. Legal in any state.
//   - A byte fetch in the same cycle returns the old data.
//   - Later fetches see the new data.
// - If ss_n falls in the same cycle that it is released: IDLE takes priority. The next fall starts a new CMD.
// CONFIGURATION
// - SPI_FLASH_FAST_READ_EN defined: opcode 0x0B is also accepted.
//   - Path: ADDR (24 bits) -> DUMMY, which counts 8 sck_rise -> DATA. Byte fetch happens on the last dummy rise.
//   - spi_miso=0 during DUMMY.
// - SPI_FLASH_FAST_READ_EN undefined: 0x0B is treated as unsupported -> IGNORE, bad_cmd pulse.
// TESTING
// - Load mem[1]=0xDEADBEEF; ss_n low; send 0x03,0x000004; clock 32 bits.
//   -> miso bytes DE AD BE EF; active=1 throughout.
// - Load mem[MEM_WORDS-1]=0x11223344, mem[0]=0x55667788; read from byte 4*MEM_WORDS-2, 4 bytes.
//   -> 33 44 55 66 (wrap).
// - Send opcode 0x9F plus 16 clocks.
//   -> bad_cmd pulses once after the 8th rise; miso stays 0; ss_n high -> active=0.
// - ss_n high after 12 address bits, then a full read of 0x000000 with mem[0]=0xCAFEF00D.
//   -> CA FE F0 0D (no residue).
// - Assert reset during DATA.
//   -> miso=0, active=0 next cycle; SCK edges are ignored until ss_n toggles.
// - Define SPI_FLASH_FAST_READ_EN; send 0x0B, 0x000004, 8 dummy clocks with mem[1]=0xA5A5_5A5A.
//   -> miso 0 during dummy, then A5 A5 5A 5A.
//   - Without the macro: bad_cmd pulse.

Source files
------------

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash responder answering READ (0x03) from a backdoor-loaded word memory.
// Optional SPI_FLASH_FAST_READ_EN adds FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         spi_sck,
    input  logic                         spi_ss_n,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic                         active,
    output logic                         bad_cmd
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = AW + 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        DUMMY,
`endif
        DATA,
        IGNORE
    } state_t;

    logic [31:0] mem [MEM_WORDS];

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;
    logic                   sck_s, ss_s, mosi_s, sck_rise, sck_fall, ss_fall;

    state_t        state_q, state_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-2:0] sh_q, sh_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [7:0]    tx_q, tx_d;
    logic          skip_q, skip_d;
    logic          bad_cmd_q, bad_cmd_d;
`ifdef SPI_FLASH_FAST_READ_EN
    logic          fast_q, fast_d;
`endif

    logic [BW-1:0] shift_in, fetch_addr;
    logic [31:0]   fetch_word;
    logic [7:0]    fetch_byte;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    // ss chain resets low so a select held through reset never looks like a new fall
    assign ss_fall  = ~ss_s & ss_prev_q;
    assign shift_in = {sh_q, mosi_s};

    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        fetch_addr = addr_q;
        if (state_q == ADDR) begin
            fetch_addr = shift_in;
        end else if (state_q == DATA) begin
            fetch_addr = addr_q + BW'(1);
        end
    end

    assign fetch_word = mem[fetch_addr[BW-1:2]];

    always_comb begin
        case (fetch_addr[1:0])
            2'd0:    fetch_byte = fetch_word[31:24];
            2'd1:    fetch_byte = fetch_word[23:16];
            2'd2:    fetch_byte = fetch_word[15:8];
            default: fetch_byte = fetch_word[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        skip_d    = skip_q;
        bad_cmd_d = 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
        fast_d    = fast_q;
`endif
        if (ss_s) begin
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = 5'd0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        sh_d      = shift_in[BW-2:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (shift_in[7:0] == 8'h03) begin
                                state_d = ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                                fast_d  = 1'b0;
                            end else if (shift_in[7:0] == 8'h0B) begin
                                state_d = ADDR;
                                fast_d  = 1'b1;
`endif
                            end else begin
                                state_d   = IGNORE;
                                bad_cmd_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        sh_d      = shift_in[BW-2:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = shift_in;
`ifdef SPI_FLASH_FAST_READ_EN
                            if (fast_q) state_d = DUMMY;
                            else
`endif
                            begin
                                state_d = DATA;
                                tx_d    = fetch_byte;
                                skip_d  = 1'b1;
                            end
                        end
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                DUMMY: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = DATA;
                            tx_d      = fetch_byte;
                            skip_d    = 1'b1;
                        end
                    end
                end
`endif
                DATA: begin
                    // the fall closing the last address/dummy bit must not consume the MSB
                    if (sck_fall) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = addr_q + BW'(1);
                            tx_d      = fetch_byte;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            tx_d      = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            sh_q        <= '0;
            addr_q      <= '0;
            tx_q        <= 8'd0;
            skip_q      <= 1'b0;
            bad_cmd_q   <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            sck_sync_q[0]  <= spi_sck;
            ss_sync_q[0]   <= spi_ss_n;
            mosi_sync_q[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync_q[i]  <= sck_sync_q[i-1];
                ss_sync_q[i]   <= ss_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sck_prev_q <= sck_s;
            ss_prev_q  <= ss_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            skip_q     <= skip_d;
            bad_cmd_q  <= bad_cmd_d;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_q     <= fast_d;
`endif
        end
    end

    assign spi_miso = (state_q == DATA) & tx_q[7];
    assign active   = (state_q != IDLE);
    assign bad_cmd  = bad_cmd_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - randomized bench for spi_flash_responder against a byte-addressed memory model.
module tb_spi_flash_responder;
    localparam int MW   = 1024;
    localparam int AW   = 10;
    localparam int NB   = 4 * MW;
    localparam int HALF = 6;

    logic          clock = 1'b0;
    logic          reset, spi_sck, spi_ss_n, spi_mosi, spi_miso;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          active, bad_cmd;

    int n_cmp = 0;
    int n_err = 0;
    int bad_cnt = 0;
    int miso_hi_cnt = 0;
    logic [31:0] model [MW];

    spi_flash_responder #(.MEM_WORDS(MW), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_ss_n (spi_ss_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .active   (active),
        .bad_cmd  (bad_cmd)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bad_cmd) bad_cnt <= bad_cnt + 1;
        if (spi_miso) miso_hi_cnt <= miso_hi_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        clk(1);
        load_en   = 1'b0;
        model[a]  = d;
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        int b;
        logic [31:0] w;
        b = a % NB;
        w = model[b / 4];
        return 8'((w >> (8 * (3 - (b % 4)))) & 32'hFF);
    endfunction

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            clk(HALF);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic sel();
        spi_ss_n = 1'b0;
        clk(HALF);
    endtask

    task automatic desel();
        spi_ss_n = 1'b1;
        clk(HALF);
    endtask

    task automatic do_read(input string tag, input logic [7:0] op, input logic [23:0] a24, input int n);
        logic [7:0] rx;
        sel();
        xfer(op, 8, rx);
        xfer(a24[23:16], 8, rx);
        xfer(a24[15:8], 8, rx);
        xfer(a24[7:0], 8, rx);
        if (op == 8'h0B) begin
            xfer(8'hFF, 8, rx);
            chk({tag, " dummy miso"}, 32'(rx), 32'h0);
        end
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, 8, rx);
            chk($sformatf("%s byte%0d", tag, k), 32'(rx), 32'(exp_byte(int'(a24) + k)));
        end
        chk({tag, " active"}, 32'(active), 32'h1);
        desel();
        chk({tag, " active off"}, 32'(active), 32'h0);
        chk({tag, " miso off"}, 32'(spi_miso), 32'h0);
    endtask

    task automatic bad_opcode(input string tag, input logic [7:0] op);
        logic [7:0] rx;
        int b0, m0;
        sel();
        b0 = bad_cnt;
        m0 = miso_hi_cnt;
        xfer(op, 8, rx);
        xfer(8'hA5, 8, rx);
        xfer(8'h5A, 8, rx);
        clk(2);
        chk({tag, " bad_cmd pulses"}, 32'(bad_cnt - b0), 32'd1);
        chk({tag, " miso quiet"}, 32'(miso_hi_cnt - m0), 32'd0);
        chk({tag, " active"}, 32'(active), 32'h1);
        desel();
        chk({tag, " active off"}, 32'(active), 32'h0);
    endtask

    initial begin
        logic [7:0] rx;
        int m0, a;
        reset = 1'b1; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        clk(3);
        chk("reset miso", 32'(spi_miso), 32'h0);
        chk("reset active", 32'(active), 32'h0);
        chk("reset bad_cmd", 32'(bad_cmd), 32'h0);
        reset = 1'b0;
        clk(HALF);

        for (int i = 0; i < MW; i++) load(i, $urandom);

        load(1, 32'hDEADBEEF);
        do_read("basic", 8'h03, 24'h000004, 4);

        load(MW - 1, 32'h11223344);
        load(0, 32'h55667788);
        do_read("wrap", 8'h03, 24'(NB - 2), 4);

        bad_opcode("op9f", 8'h9F);

        load(0, 32'hCAFEF00D);
        sel();
        xfer(8'h03, 8, rx);
        xfer(8'hFF, 8, rx);
        xfer(8'hFF, 4, rx);
        desel();
        chk("abort active off", 32'(active), 32'h0);
        do_read("after abort", 8'h03, 24'h000000, 4);

        sel();
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx);
        chk("pre-reset byte", 32'(rx), 32'hCA);
        reset = 1'b1;
        clk(1);
        reset = 1'b0;
        chk("mid reset miso", 32'(spi_miso), 32'h0);
        chk("mid reset active", 32'(active), 32'h0);
        m0 = miso_hi_cnt;
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx);
        chk("post reset active", 32'(active), 32'h0);
        chk("post reset miso quiet", 32'(miso_hi_cnt - m0), 32'd0);
        desel();
        do_read("after reset", 8'h03, 24'h000000, 2);

`ifdef SPI_FLASH_FAST_READ_EN
        load(1, 32'hA5A55A5A);
        do_read("fast", 8'h0B, 24'h000004, 4);
`else
        bad_opcode("op0b", 8'h0B);
`endif

        sel();
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h08, 8, rx);
        xfer(8'h00, 8, rx);
        chk("bd byte8", 32'(rx), 32'(exp_byte(8)));
        load(3, 32'h0BADC0DE);
        for (int k = 9; k < 16; k++) begin
            xfer(8'h00, 8, rx);
            chk($sformatf("bd byte%0d", k), 32'(rx), 32'(exp_byte(k)));
        end
        desel();

        for (int t = 0; t < 10; t++) begin
            if (t % 3 == 0) a = NB - int'($urandom_range(1, 3));
            else a = int'($urandom_range(0, NB - 1));
            a = a + (int'($urandom_range(0, 255)) << 12);
            load(int'($urandom_range(0, MW - 1)), $urandom);
            do_read($sformatf("rnd%0d", t), 8'h03, 24'(a), int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
